demux_16w_1_to_8: RTL

Registered 16-bit, 1-to-8 stream demultiplexer: the write/distribute counterpart of the processor's 8-to-1 read-select path. It accepts one word plus a 3-bit destination select over a valid/ready handshake, holds it in a single output stage, and presents it to exactly one of eight downstream consumers until that consumer accepts it. It sits between the datapath result bus and the eight destination ports (register write-back, I/O latches), and guarantees each word is delivered once to the selected destination only.

---
 rtl/demux_pkg.sv | 16 +
 rtl/decoder_3_to_8.sv | 17 +
 rtl/demux_16w_1_to_8.sv | 88 ++++++++
 3 files changed

// File: rtl/demux_pkg.sv
// rtl/demux_pkg.sv - shared constants and types for the 16-bit 1-to-8 demultiplexer
package demux_pkg;

    localparam int DATA_W    = 16;
    localparam int NUM_PORTS = 8;
    localparam int SEL_W     = 3;
    localparam int CNT_W     = 16;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } demux_state_t;

    typedef logic [DATA_W-1:0] word_t;

endpackage

// File: rtl/decoder_3_to_8.sv
// rtl/decoder_3_to_8.sv - combinational 3-bit index plus enable to 8-bit one-hot decoder
module decoder_3_to_8
    import demux_pkg::*;
(
    input  logic [SEL_W-1:0]     idx,
    input  logic                 en,
    output logic [NUM_PORTS-1:0] onehot
);

    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/demux_16w_1_to_8.sv
// rtl/demux_16w_1_to_8.sv - registered 16-bit 1-to-8 stream demultiplexer with transfer counter
module demux_16w_1_to_8
    import demux_pkg::*;
(
    input  logic                 Clk,
    input  logic                 Reset_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [SEL_W-1:0]     in_sel,
    input  word_t                in_data,
    output logic [NUM_PORTS-1:0] out_valid,
    input  logic [NUM_PORTS-1:0] out_ready,
    output word_t                out_data,
    output logic [SEL_W-1:0]     out_sel,
    output logic [CNT_W-1:0]     xfer_count
);

    demux_state_t     state_q;
    demux_state_t     state_d;
    word_t            data_q;
    logic [SEL_W-1:0] sel_q;
    logic [CNT_W-1:0] count_q;
    logic             sel_ready;
    logic             xfer;
    logic             accept;

    // Only the selected destination's ready matters; the others are ignored.
    always_comb begin
        sel_ready = out_ready[sel_q];
        xfer      = (state_q == FULL) && sel_ready;
        in_ready  = (state_q == EMPTY) || sel_ready;
        accept    = in_valid && in_ready;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY: begin
                if (accept) begin
                    state_d = FULL;
                end
            end
            FULL: begin
                if (xfer && !accept) begin
                    state_d = EMPTY;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            data_q <= '0;
            sel_q  <= '0;
        end else if (accept) begin
            data_q <= in_data;
            sel_q  <= in_sel;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            count_q <= '0;
        end else if (xfer) begin
            count_q <= count_q + 1'b1;
        end
    end

    decoder_3_to_8 u_valid_dec (
        .idx    (sel_q),
        .en     (state_q == FULL),
        .onehot (out_valid)
    );

    assign out_data   = data_q;
    assign out_sel    = sel_q;
    assign xfer_count = count_q;

endmodule
